// File: rtl/referee_merge.sv
// -----------------------------------------------------------------------------
// referee_merge
//
// Egress-side referee. Merges four source FIFOs (one per virtual channel) into
// a single destination FIFO. It pops at most one source per cycle and forwards
// the word with a registered push. Pop-to-push latency is two cycles.
//
// Optional feature macro: REFEREE_MERGE_ROUND_ROBIN_EN
//   undefined : fixed priority arbitration, port 0 highest.
//   defined   : round-robin arbitration using a 2-bit last-grant pointer.
//
// Ports
//   clk                 system clock, rising edge
//   reset               synchronous, active-high reset
//   empty_0..empty_3    source FIFO i empty
//   data_in_0..3        source FIFO i read data, valid the cycle after pop_i
//   almost_full         destination FIFO almost full
//   pop_0..pop_3        pop source FIFO i (combinational, one-hot or zero)
//   push                push into destination FIFO (registered)
//   data_out            destination write data (registered, valid with push)
//   idle                no eligible source and nothing in flight (registered)
//   word_count          pushes since reset, wraps
// -----------------------------------------------------------------------------
module referee_merge #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    input  logic                  almost_full,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    output logic                  push,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  idle,
    output logic [CNT_WIDTH-1:0]  word_count
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  v1_q, v1_d;
    logic [1:0]            sel1_q, sel1_d;
    logic                  push_q, push_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic                  idle_q, idle_d;

    logic [3:0]            elig;
    logic                  any_elig;
    logic [1:0]            grant_idx;
    logic [3:0]            pop;
    logic                  pop_any;
    logic                  pop_en;
    logic [DATA_WIDTH-1:0] sel_data;

    assign elig     = ~{empty_3, empty_2, empty_1, empty_0};
    assign any_elig = |elig;

`ifdef REFEREE_MERGE_ROUND_ROBIN_EN
    logic [1:0] last_grant_q, last_grant_d;
    logic [1:0] cand;
    logic       found;

    // Round-robin search: first eligible source starting after the last grant.
    always_comb begin
        grant_idx = 2'd0;
        found     = 1'b0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + k[1:0];
            if (!found && elig[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end else begin
                found     = found;
            end
        end
    end

    // Pointer moves only on cycles that actually pop.
    always_comb begin
        if (pop_any) begin
            last_grant_d = grant_idx;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Round-robin pointer register; reset to 3 so port 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 2'd3;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority search, port 0 highest.
    always_comb begin
        grant_idx = 2'd0;
        if (elig[0]) begin
            grant_idx = 2'd0;
        end else if (elig[1]) begin
            grant_idx = 2'd1;
        end else if (elig[2]) begin
            grant_idx = 2'd2;
        end else if (elig[3]) begin
            grant_idx = 2'd3;
        end else begin
            grant_idx = 2'd0;
        end
    end
`endif

    // Pop decode: only from IDLE/ACTIVE, never under backpressure or reset.
    always_comb begin
        pop_en = ~reset & ~almost_full &
                 ((state_q == ST_IDLE) | (state_q == ST_ACTIVE));
        if (pop_en && any_elig) begin
            pop = 4'b0001 << grant_idx;
        end else begin
            pop = 4'b0000;
        end
        pop_any = |pop;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_elig && !almost_full) begin
                    state_d = ST_ACTIVE;
                end else if (any_elig) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (almost_full) begin
                    state_d = ST_HOLD;
                end else if (!any_elig) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_HOLD: begin
                if (almost_full) begin
                    state_d = ST_HOLD;
                end else if (any_elig) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Read-data mux driven by the index captured in stage 1.
    always_comb begin
        case (sel1_q)
            2'd0:    sel_data = data_in_0;
            2'd1:    sel_data = data_in_1;
            2'd2:    sel_data = data_in_2;
            2'd3:    sel_data = data_in_3;
            default: sel_data = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Two-stage forward pipeline, counter and idle flag.
    always_comb begin
        v1_d   = pop_any;
        push_d = v1_q;
        if (pop_any) begin
            sel1_d = grant_idx;
        end else begin
            sel1_d = sel1_q;
        end
        // data_out holds its last pushed value between pushes.
        if (v1_q) begin
            data_out_d = sel_data;
        end else begin
            data_out_d = data_out_q;
        end
        word_count_d = word_count_q + {{(CNT_WIDTH-1){1'b0}}, push_q};
        idle_d       = (&(~elig)) & ~v1_q & ~push_q;
    end

    // State and pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            v1_q         <= 1'b0;
            sel1_q       <= 2'd0;
            push_q       <= 1'b0;
            data_out_q   <= {DATA_WIDTH{1'b0}};
            word_count_q <= {CNT_WIDTH{1'b0}};
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            v1_q         <= v1_d;
            sel1_q       <= sel1_d;
            push_q       <= push_d;
            data_out_q   <= data_out_d;
            word_count_q <= word_count_d;
            idle_q       <= idle_d;
        end
    end

    assign pop_0      = pop[0];
    assign pop_1      = pop[1];
    assign pop_2      = pop[2];
    assign pop_3      = pop[3];
    assign push       = push_q;
    assign data_out   = data_out_q;
    assign idle       = idle_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_referee_merge.sv
// -----------------------------------------------------------------------------
// tb_referee_merge
//
// Self-checking bench for referee_merge. A directed table covers reset and a
// single-source burst; short sequences cover backpressure, arbitration, reset
// mid-burst and counter wrap; a random phase follows. Every cycle the outputs
// of two instances (CNT_WIDTH 16 and 4) are compared with a behavioural model
// that tracks the mode, the next winner and a per-cycle schedule of pushes.
// -----------------------------------------------------------------------------
module tb_referee_merge;

    localparam int DW = 12;
    localparam int M_INIT   = 0;
    localparam int M_IDLE   = 1;
    localparam int M_ACTIVE = 2;
    localparam int M_HOLD   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    empty;
    logic [DW-1:0] din [4];
    logic          af;

    logic [3:0]    pop;
    logic          push;
    logic [DW-1:0] dout;
    logic          idle;
    logic [15:0]   wc;

    logic [3:0]    pop_b;
    logic          push_b;
    logic [DW-1:0] dout_b;
    logic          idle_b;
    logic [3:0]    wc_b;

    always #5 clk = ~clk;

    referee_merge #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .empty_0(empty[0]), .empty_1(empty[1]), .empty_2(empty[2]), .empty_3(empty[3]),
        .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
        .almost_full(af),
        .pop_0(pop[0]), .pop_1(pop[1]), .pop_2(pop[2]), .pop_3(pop[3]),
        .push(push), .data_out(dout), .idle(idle), .word_count(wc)
    );

    referee_merge #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w4 (
        .clk(clk), .reset(reset),
        .empty_0(empty[0]), .empty_1(empty[1]), .empty_2(empty[2]), .empty_3(empty[3]),
        .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
        .almost_full(af),
        .pop_0(pop_b[0]), .pop_1(pop_b[1]), .pop_2(pop_b[2]), .pop_3(pop_b[3]),
        .push(push_b), .data_out(dout_b), .idle(idle_b), .word_count(wc_b)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int push_cnt = 0;

    // Reference model state
    int            cyc;
    bit            exp_push [0:8191];
    logic [DW-1:0] m_dout;
    bit            m_idle;
    logic [15:0]   m_cnt;
    int            m_mode;
    int            prev_sel;
`ifdef REFEREE_MERGE_ROUND_ROBIN_EN
    int            m_last;
`endif

    typedef struct {
        bit          rst;
        logic [3:0]  empty;
        bit          af;
        logic [11:0] d2;
        logic [3:0]  pop;
        bit          push;
        logic [11:0] dout;
        logic [15:0] cnt;
        bit          idle;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Source that wins arbitration this cycle, -1 if nothing is eligible.
    function automatic int winner();
        int w;
        w = -1;
`ifdef REFEREE_MERGE_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            if (w < 0 && !empty[(m_last + k) % 4]) w = (m_last + k) % 4;
        end
`else
        for (int i = 0; i < 4; i++) begin
            if (w < 0 && !empty[i]) w = i;
        end
`endif
        return w;
    endfunction

    // Compare current outputs to the model, then advance the model one clock.
    task automatic model_step();
        int         win;
        bit         popn;
        bit         any_el;
        logic [3:0] exp_pop;
        any_el  = (empty != 4'hF);
        win     = winner();
        popn    = !reset && !af && any_el && (m_mode == M_IDLE || m_mode == M_ACTIVE);
        exp_pop = popn ? (4'b0001 << win) : 4'b0000;

        check("pop", pop, exp_pop);
        check("push", push, exp_push[cyc]);
        check("data_out", dout, m_dout);
        check("idle", idle, m_idle);
        check("word_count", wc, m_cnt);
        check("pop_w4", pop_b, exp_pop);
        check("push_w4", push_b, exp_push[cyc]);
        check("word_count_w4", wc_b, m_cnt[3:0]);
        if (push === 1'b1) push_cnt++;

        exp_push[cyc+1] = !reset && (prev_sel >= 0);
        m_cnt  = reset ? 16'd0 : m_cnt + (exp_push[cyc] ? 16'd1 : 16'd0);
        m_idle = reset ? 1'b1 : (!any_el && prev_sel < 0 && !exp_push[cyc]);
        if (reset)             m_dout = '0;
        else if (prev_sel >= 0) m_dout = din[prev_sel];

        if (reset) m_mode = M_INIT;
        else begin
            case (m_mode)
                M_INIT:   m_mode = M_IDLE;
                M_IDLE:   m_mode = any_el ? (af ? M_HOLD : M_ACTIVE) : M_IDLE;
                M_ACTIVE: m_mode = af ? M_HOLD : (any_el ? M_ACTIVE : M_IDLE);
                default:  m_mode = af ? M_HOLD : (any_el ? M_ACTIVE : M_IDLE);
            endcase
        end
`ifdef REFEREE_MERGE_ROUND_ROBIN_EN
        if (reset)     m_last = 3;
        else if (popn) m_last = win;
`endif
        prev_sel = popn ? win : -1;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_rand();
        for (int i = 0; i < 4; i++) din[i] = DW'($urandom);
        tick();
    endtask

    initial begin
        // rst, empty{3..0}, af, din2 | pop, push, dout, cnt, idle
        tbl[0] = '{1'b1, 4'b0000, 1'b0, 12'h000, 4'b0000, 1'b0, 12'h000, 16'd0, 1'b1};
        tbl[1] = '{1'b1, 4'b0000, 1'b0, 12'h000, 4'b0000, 1'b0, 12'h000, 16'd0, 1'b1};
        tbl[2] = '{1'b0, 4'b1011, 1'b0, 12'h000, 4'b0000, 1'b0, 12'h000, 16'd0, 1'b1};
        tbl[3] = '{1'b0, 4'b1011, 1'b0, 12'h000, 4'b0100, 1'b0, 12'h000, 16'd0, 1'b0};
        tbl[4] = '{1'b0, 4'b1011, 1'b0, 12'h0A1, 4'b0100, 1'b0, 12'h000, 16'd0, 1'b0};
        tbl[5] = '{1'b0, 4'b1011, 1'b0, 12'h0A2, 4'b0100, 1'b1, 12'h0A1, 16'd0, 1'b0};
        tbl[6] = '{1'b0, 4'b1111, 1'b0, 12'h0A3, 4'b0000, 1'b1, 12'h0A2, 16'd1, 1'b0};
        tbl[7] = '{1'b0, 4'b1111, 1'b0, 12'h000, 4'b0000, 1'b1, 12'h0A3, 16'd2, 1'b0};
        tbl[8] = '{1'b0, 4'b1111, 1'b0, 12'h000, 4'b0000, 1'b0, 12'h0A3, 16'd3, 1'b0};
        tbl[9] = '{1'b0, 4'b1111, 1'b0, 12'h000, 4'b0000, 1'b0, 12'h0A3, 16'd3, 1'b1};

        reset = 1'b1;
        empty = 4'hF;
        af    = 1'b0;
        din[0] = 12'h100; din[1] = 12'h111; din[2] = 12'h000; din[3] = 12'h333;
        @(posedge clk);
        #1;
        cyc = 0; exp_push[0] = 1'b0; m_dout = '0; m_idle = 1'b1; m_cnt = 16'd0;
        m_mode = M_INIT; prev_sel = -1;
`ifdef REFEREE_MERGE_ROUND_ROBIN_EN
        m_last = 3;
`endif

        // Reset and single-source burst from port 2
        for (int i = 0; i < 10; i++) begin
            reset  = tbl[i].rst;
            empty  = tbl[i].empty;
            af     = tbl[i].af;
            din[2] = tbl[i].d2;
            @(negedge clk);
            check("tbl_pop", pop, tbl[i].pop);
            check("tbl_push", push, tbl[i].push);
            check("tbl_data_out", dout, tbl[i].dout);
            check("tbl_word_count", wc, tbl[i].cnt);
            check("tbl_idle", idle, tbl[i].idle);
            model_step();
            @(posedge clk);
            #1;
        end

        // Backpressure while streaming from port 1
        empty = 4'b1101;
        repeat (4) tick_rand();
        af = 1'b1;
        push_cnt = 0;
        repeat (4) tick_rand();
        check("bp_pushes_after_af", push_cnt, 2);
        af = 1'b0;
        repeat (5) tick_rand();

        // Arbitration with every source eligible, tagged data
        empty = 4'b0000;
        for (int i = 0; i < 4; i++) din[i] = DW'(12'hA00 + 12'(i * 17));
        repeat (8) tick();
        empty = 4'hF;
        repeat (4) tick();

        // Reset in the middle of a burst from port 0
        empty = 4'b1110;
        repeat (5) tick_rand();
        reset = 1'b1;
        tick_rand();
        reset = 1'b0;
        push_cnt = 0;
        repeat (3) tick_rand();
        check("rst_dropped_words", push_cnt, 0);

        // Long stream to carry the 4-bit counter through its wrap
        repeat (22) tick_rand();
        empty = 4'hF;
        repeat (4) tick();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            empty = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            af    = ($urandom_range(0, 4) == 0);
            tick_rand();
        end
        reset = 1'b0;
        af    = 1'b0;
        empty = 4'hF;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
